// File: rtl/rails_pkg.sv
// rtl/rails_pkg.sv - shared states, sizes and grant constants for the rails arbiter
package rails_pkg;

  localparam int DW      = 4;
  localparam int MAX_LEN = 10;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  localparam logic GNT_REQ0 = 1'b0;
  localparam logic GNT_REQ1 = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_t;

endpackage

// File: rtl/rails_seq_buf.sv
// rtl/rails_seq_buf.sv - frame element store: indexed write, combinational read
module rails_seq_buf
  import rails_pkg::*;
#(
  parameter int DEPTH = MAX_LEN,
  parameter int WIDTH = DW,
  parameter int IDX_W = LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Element write; out-of-range indices are dropped rather than aliased.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && (int'(wr_idx) < DEPTH)) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // The RUN counter can sit one past the last element; read zero there.
  assign rd_data = (int'(rd_idx) < DEPTH) ? mem[rd_idx] : '0;

endmodule

// File: rtl/rails_arbiter.sv
// rtl/rails_arbiter.sv - round-robin front end sharing one rails checker between two requesters
// Optional watchdog in WAIT enabled by defining RAILS_ARB_TIMEOUT_EN.
module rails_arbiter
  import rails_pkg::*;
`ifdef RAILS_ARB_TIMEOUT_EN
#(
  parameter int TIMEOUT = 32
)
`endif
(
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          rsp0_valid,
  output logic          rsp1_valid,
  output logic          rsp_result,
  output logic          rsp_err,
  output logic          chk_reset,
  output logic [DW-1:0] chk_data,
  input  logic          chk_valid,
  input  logic          chk_result
);

  state_t           state, state_d;
  logic             gnt, gnt_d;
  logic             last_grant, last_grant_d;
  logic             have_len, have_len_d;
  logic [LEN_W-1:0] len, len_d;
  logic [LEN_W-1:0] idx, idx_d, idx_inc;
  logic [LEN_W-1:0] run_cnt, run_cnt_d, rd_idx;
  logic             req0_ready_d, req1_ready_d;
  logic             rsp0_valid_d, rsp1_valid_d;
  logic             rsp_result_d, rsp_err_d;
  logic             chk_reset_d;
  logic [DW-1:0]    chk_data_d;
  logic             acc;
  logic [DW-1:0]    beat;
  logic             wr_en;
  logic [DW-1:0]    rd_data;

`ifdef RAILS_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt, wd_cnt_d;
`endif

  assign acc     = (gnt == GNT_REQ1) ? (req1_valid & req1_ready) : (req0_valid & req0_ready);
  assign beat    = (gnt == GNT_REQ1) ? req1_data : req0_data;
  assign idx_inc = idx + 1'b1;
  assign rd_idx  = run_cnt - 1'b1;

  rails_seq_buf #(
    .DEPTH (MAX_LEN),
    .WIDTH (DW),
    .IDX_W (LEN_W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_data (beat),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // Next-state and next-register values; every registered output is computed here.
  always_comb begin
    state_d      = state;
    gnt_d        = gnt;
    last_grant_d = last_grant;
    have_len_d   = have_len;
    len_d        = len;
    idx_d        = idx;
    run_cnt_d    = run_cnt;
    req0_ready_d = req0_ready;
    req1_ready_d = req1_ready;
    rsp0_valid_d = rsp0_valid;
    rsp1_valid_d = rsp1_valid;
    rsp_result_d = rsp_result;
    rsp_err_d    = rsp_err;
    chk_reset_d  = chk_reset;
    chk_data_d   = chk_data;
    wr_en        = 1'b0;
`ifdef RAILS_ARB_TIMEOUT_EN
    wd_cnt_d     = wd_cnt;
`endif

    case (state)
      IDLE: begin
        chk_reset_d = 1'b1;
        chk_data_d  = '0;
        if (req0_valid || req1_valid) begin
          if (req0_valid && req1_valid) gnt_d = ~last_grant;
          else if (req1_valid)          gnt_d = GNT_REQ1;
          else                          gnt_d = GNT_REQ0;
          req0_ready_d = (gnt_d == GNT_REQ0);
          req1_ready_d = (gnt_d == GNT_REQ1);
          have_len_d   = 1'b0;
          idx_d        = '0;
          state_d      = LOAD;
        end
      end

      LOAD: begin
        if (acc) begin
          if (!have_len) begin
            if ((beat == '0) || (int'(beat) > MAX_LEN)) begin
              // Bad length: answer with an error and leave the rest of the frame unread.
              req0_ready_d = 1'b0;
              req1_ready_d = 1'b0;
              rsp0_valid_d = (gnt == GNT_REQ0);
              rsp1_valid_d = (gnt == GNT_REQ1);
              rsp_result_d = 1'b0;
              rsp_err_d    = 1'b1;
              state_d      = RESP;
            end else begin
              len_d      = LEN_W'(beat);
              have_len_d = 1'b1;
            end
          end else begin
            wr_en = 1'b1;
            idx_d = idx_inc;
            if (idx_inc == len) begin
              req0_ready_d = 1'b0;
              req1_ready_d = 1'b0;
              chk_reset_d  = 1'b0;
              run_cnt_d    = '0;
              state_d      = RUN;
            end
          end
        end
      end

      RUN: begin
        // Step 0 sends the length, steps 1..len the buffered elements back to back.
        run_cnt_d  = run_cnt + 1'b1;
        chk_data_d = (run_cnt == '0) ? DW'(len) : rd_data;
        if (run_cnt == len) begin
          state_d = WAIT;
`ifdef RAILS_ARB_TIMEOUT_EN
          wd_cnt_d = '0;
`endif
        end
      end

      WAIT: begin
        chk_data_d = '0;
        if (chk_valid) begin
          rsp0_valid_d = (gnt == GNT_REQ0);
          rsp1_valid_d = (gnt == GNT_REQ1);
          rsp_result_d = chk_result;
          rsp_err_d    = 1'b0;
          chk_reset_d  = 1'b1;
          state_d      = RESP;
        end
`ifdef RAILS_ARB_TIMEOUT_EN
        else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
          rsp0_valid_d = (gnt == GNT_REQ0);
          rsp1_valid_d = (gnt == GNT_REQ1);
          rsp_result_d = 1'b0;
          rsp_err_d    = 1'b1;
          chk_reset_d  = 1'b1;
          state_d      = RESP;
        end else begin
          wd_cnt_d = wd_cnt + 1'b1;
        end
`endif
      end

      RESP: begin
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp_result_d = 1'b0;
        rsp_err_d    = 1'b0;
        last_grant_d = gnt;
        idx_d        = '0;
        have_len_d   = 1'b0;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any frame in flight and holds the checker in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      gnt        <= GNT_REQ0;
      last_grant <= GNT_REQ1;
      have_len   <= 1'b0;
      len        <= '0;
      idx        <= '0;
      run_cnt    <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_result <= 1'b0;
      rsp_err    <= 1'b0;
      chk_reset  <= 1'b1;
      chk_data   <= '0;
`ifdef RAILS_ARB_TIMEOUT_EN
      wd_cnt     <= '0;
`endif
    end else begin
      state      <= state_d;
      gnt        <= gnt_d;
      last_grant <= last_grant_d;
      have_len   <= have_len_d;
      len        <= len_d;
      idx        <= idx_d;
      run_cnt    <= run_cnt_d;
      req0_ready <= req0_ready_d;
      req1_ready <= req1_ready_d;
      rsp0_valid <= rsp0_valid_d;
      rsp1_valid <= rsp1_valid_d;
      rsp_result <= rsp_result_d;
      rsp_err    <= rsp_err_d;
      chk_reset  <= chk_reset_d;
      chk_data   <= chk_data_d;
`ifdef RAILS_ARB_TIMEOUT_EN
      wd_cnt     <= wd_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_rails_arbiter.sv
// tb/tb_rails_arbiter.sv - directed bench for rails_arbiter with a behavioural rails checker
module tb_rails_arbiter;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   req0_valid = 1'b0;
  logic [rails_pkg::DW-1:0] req0_data = '0;
  logic                   req0_ready;
  logic                   req1_valid = 1'b0;
  logic [rails_pkg::DW-1:0] req1_data = '0;
  logic                   req1_ready;
  logic                   rsp0_valid, rsp1_valid, rsp_result, rsp_err;
  logic                   chk_reset;
  logic [rails_pkg::DW-1:0] chk_data;
  logic                   chk_valid = 1'b0;
  logic                   chk_result = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  bit mute = 1'b0;
  bit spur = 1'b0;
  bit watch_r1 = 1'b0, watch_cr = 1'b0, watch_rsp = 1'b0;
  bit r1_early, cr_low, rsp_bad;

  logic [3:0] cap [0:31];
  int cap_n = 0;
  int fire_in = 0;
  int frm[$];
  int lat;

  rails_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .chk_reset  (chk_reset),
    .chk_data   (chk_data),
    .chk_valid  (chk_valid),
    .chk_result (chk_result)
  );

  always #5 clk = ~clk;

  // Rails station verdict over the captured elements cap[2..n+1].
  function automatic logic rails_ok(input int n);
    int stk[32];
    int sp;
    int nxt;
    int t;
    sp = 0;
    nxt = 1;
    for (int i = 0; i < n; i++) begin
      t = int'(cap[i + 2]);
      while (nxt <= t && sp < 32) begin
        stk[sp] = nxt;
        sp++;
        nxt++;
      end
      if (sp > 0 && stk[sp - 1] == t) sp--;
      else return 1'b0;
    end
    return 1'b1;
  endfunction

  // Checker model: logs chk_data while out of reset, answers two cycles after the last element.
  always @(negedge clk) begin
    chk_valid = 1'b0;
    if (chk_reset !== 1'b0) begin
      cap_n = 0;
      fire_in = 0;
    end else begin
      if (cap_n < 32) cap[cap_n] = chk_data;
      cap_n++;
      if (cap_n >= 2 && cap_n == int'(cap[1]) + 2 && !mute) fire_in = 2;
      if (fire_in > 0) begin
        fire_in--;
        if (fire_in == 0) begin
          chk_valid  = 1'b1;
          chk_result = rails_ok(int'(cap[1]));
        end
      end
      if (spur && cap_n == 2) begin
        chk_valid  = 1'b1;
        chk_result = 1'b1;
      end
    end
  end

  // Sticky observers for conditions that must hold over a whole interval.
  always @(negedge clk) begin
    if (!watch_r1) r1_early = 1'b0;
    else if (req1_ready) r1_early = 1'b1;
    if (!watch_cr) cr_low = 1'b0;
    else if (chk_reset !== 1'b1) cr_low = 1'b1;
    if (!watch_rsp) rsp_bad = 1'b0;
    else if (rsp0_valid || rsp1_valid) rsp_bad = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int r, input logic v, input logic [3:0] d);
    if (r == 0) begin
      req0_valid = v;
      req0_data  = d;
    end else begin
      req1_valid = v;
      req1_data  = d;
    end
  endtask

  task automatic send_beat(input int r, input logic [3:0] d);
    int t;
    logic a;
    t = 0;
    a = 1'b0;
    drive(r, 1'b1, d);
    while (!a && t < 200) begin
      a = (r == 0) ? req0_ready : req1_ready;
      @(negedge clk);
      t++;
    end
    check("beat_accepted", 32'(a), 1);
  endtask

  task automatic send_frame(input int r, input int stall_at);
    for (int i = 0; i < frm.size(); i++) begin
      if (i == stall_at) begin
        drive(r, 1'b0, 4'h0);
        tick(3);
      end
      send_beat(r, 4'(frm[i]));
    end
    drive(r, 1'b0, 4'h0);
  endtask

  task automatic wait_rsp(input int r, input logic exp_res, input logic exp_err,
                          input string tag, output int l);
    int t;
    t = 0;
    while (!(rsp0_valid || rsp1_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    l = t;
    check({tag, "_seen"},   32'(rsp0_valid | rsp1_valid), 1);
    check({tag, "_rsp0"},   32'(rsp0_valid), 32'(r == 0));
    check({tag, "_rsp1"},   32'(rsp1_valid), 32'(r == 1));
    check({tag, "_result"}, 32'(rsp_result), 32'(exp_res));
    check({tag, "_err"},    32'(rsp_err),    32'(exp_err));
    @(negedge clk);
    check({tag, "_pulse"},  32'(rsp0_valid | rsp1_valid), 0);
  endtask

  task automatic check_burst(input string tag);
    for (int k = 0; k < frm.size(); k++) check({tag, "_burst"}, 32'(cap[k + 1]), 32'(4'(frm[k])));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish, required finish by 100000");
    $fatal(1, "bench stopped");
  end

  initial begin
    // Reset values while reset is held.
    tick(2);
    check("rst_req0_ready", 32'(req0_ready), 0);
    check("rst_req1_ready", 32'(req1_ready), 0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 0);
    check("rst_rsp_result", 32'(rsp_result), 0);
    check("rst_rsp_err",    32'(rsp_err),    0);
    check("rst_chk_reset",  32'(chk_reset),  1);
    check("rst_chk_data",   32'(chk_data),   0);
    reset = 1'b1;
    tick(1);

    // Legal frame; burst timing fixes the latency at 1 + len + 2 checker cycles.
    frm = '{5, 1, 2, 3, 4, 5};
    send_frame(0, -1);
    wait_rsp(0, 1'b1, 1'b0, "t1", lat);
    check("t1_latency", lat, 8);
    check_burst("t1");

    // Illegal permutation; a stray chk_valid during RUN must be ignored.
    spur = 1'b1;
    frm = '{5, 5, 4, 1, 2, 3};
    send_frame(0, -1);
    wait_rsp(0, 1'b0, 1'b0, "t2", lat);
    check_burst("t2");
    spur = 1'b0;

    // Both requesters valid right after reset: req0 first, req1 held off.
    do_reset();
    drive(0, 1'b1, 4'd3);
    drive(1, 1'b1, 4'd3);
    watch_r1 = 1'b1;
    frm = '{3, 1, 2, 3};
    send_frame(0, -1);
    wait_rsp(0, 1'b1, 1'b0, "t3a", lat);
    check("t3_req1_held", 32'(r1_early), 0);
    watch_r1 = 1'b0;
    send_frame(1, -1);
    wait_rsp(1, 1'b1, 1'b0, "t3b", lat);

    // Next simultaneous request goes to req0; both carry length 0.
    watch_cr = 1'b1;
    drive(0, 1'b1, 4'd0);
    drive(1, 1'b1, 4'd0);
    tick(1);
    check("t3_rr_req0_ready", 32'(req0_ready), 1);
    check("t3_rr_req1_ready", 32'(req1_ready), 0);
    send_beat(0, 4'd0);
    drive(0, 1'b0, 4'd0);
    wait_rsp(0, 1'b0, 1'b1, "t4_len0_r0", lat);
    send_beat(1, 4'd0);
    drive(1, 1'b0, 4'd0);
    wait_rsp(1, 1'b0, 1'b1, "t4_len0_r1", lat);
    send_beat(0, 4'd11);
    drive(0, 1'b0, 4'd0);
    wait_rsp(0, 1'b0, 1'b1, "t4_len11", lat);
    check("t4_chk_reset_held", 32'(cr_low), 0);
    watch_cr = 1'b0;

    // Requester stall mid-frame still yields a gap-free burst.
    frm = '{4, 2, 1, 3, 4};
    send_frame(1, 3);
    wait_rsp(1, 1'b1, 1'b0, "t5", lat);
    check_burst("t5");

    // Reset during RUN: immediate reset values, frame dropped.
    frm = '{6, 1, 2, 3, 4, 5, 6};
    send_frame(0, -1);
    check("t6_in_run", 32'(chk_reset), 0);
    tick(2);
    #2;
    reset = 1'b0;
    #1;
    check("t6_chk_reset",  32'(chk_reset),  1);
    check("t6_chk_data",   32'(chk_data),   0);
    check("t6_req0_ready", 32'(req0_ready), 0);
    check("t6_rsp0_valid", 32'(rsp0_valid), 0);
    check("t6_rsp_err",    32'(rsp_err),    0);
    watch_rsp = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(10);
    check("t6_no_rsp", 32'(rsp_bad), 0);
    watch_rsp = 1'b0;
    frm = '{2, 2, 1};
    send_frame(0, -1);
    wait_rsp(0, 1'b1, 1'b0, "t6b", lat);
    check_burst("t6b");

`ifdef RAILS_ARB_TIMEOUT_EN
    // Mute checker: watchdog answers after 32 WAIT cycles.
    mute = 1'b1;
    frm = '{3, 1, 2, 3};
    send_frame(0, -1);
    wait_rsp(0, 1'b0, 1'b1, "t7", lat);
    check("t7_latency", lat, 3 + 1 + 32);
    mute = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
